// File: rtl/cgra_thread_issue_pkg.sv
// Shared constants, state/unroll encodings and the lane-mask helper for the thread issue block.
package dice_dispatch_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned TID_W     = 10;
    localparam int unsigned CMP_LSB   = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } issue_state_e;

    typedef enum logic [1:0] {
        UF1 = 2'b00,
        UF2 = 2'b01,
        UF4 = 2'b10
    } unroll_e;

    function automatic logic [NUM_LANES-1:0] active_mask(input unroll_e uf);
        logic [NUM_LANES-1:0] m;
        case (uf)
            UF1:     m = 4'b0001;
            UF2:     m = 4'b0011;
            UF4:     m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cgra_thread_issue_if.sv
// FIFO-head and lane-issue signal bundle between the dispatcher FIFOs, the issue block and the CGRA lanes.
interface cgra_thread_issue_if;
    import dice_dispatch_pkg::*;

    logic [2*TID_W-1:0]   fifo_data_0;
    logic [2*TID_W-1:0]   fifo_data_1;
    logic [2*TID_W-1:0]   fifo_data_2;
    logic [2*TID_W-1:0]   fifo_data_3;
    logic [NUM_LANES-1:0] fifo_data_valid;
    logic [NUM_LANES-1:0] fifo_pop;
    logic [NUM_LANES-1:0] issue_valid;
    logic [TID_W-1:0]     issue_tid_0;
    logic [TID_W-1:0]     issue_tid_1;
    logic [TID_W-1:0]     issue_tid_2;
    logic [TID_W-1:0]     issue_tid_3;
    logic [TID_W-1:0]     issue_cmp_tid_0;
    logic [TID_W-1:0]     issue_cmp_tid_1;
    logic [TID_W-1:0]     issue_cmp_tid_2;
    logic [TID_W-1:0]     issue_cmp_tid_3;
    logic [NUM_LANES-1:0] issue_ready;
    logic [NUM_LANES-1:0] retire;

    modport master (
        input  fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3, fifo_data_valid,
        input  issue_ready, retire,
        output fifo_pop, issue_valid,
        output issue_tid_0, issue_tid_1, issue_tid_2, issue_tid_3,
        output issue_cmp_tid_0, issue_cmp_tid_1, issue_cmp_tid_2, issue_cmp_tid_3
    );

    modport slave (
        output fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3, fifo_data_valid,
        output issue_ready, retire,
        input  fifo_pop, issue_valid,
        input  issue_tid_0, issue_tid_1, issue_tid_2, issue_tid_3,
        input  issue_cmp_tid_0, issue_cmp_tid_1, issue_cmp_tid_2, issue_cmp_tid_3
    );

endinterface

// File: rtl/cgra_thread_issue_slot.sv
// Per-lane issue register with valid/ready handshake and an in-flight credit counter.
module lane_issue_slot
    import dice_dispatch_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop_i,
    input  logic             retire_i,
    input  logic             issue_ready_i,
    input  logic [TID_W-1:0] head_tid_i,
    input  logic [TID_W-1:0] head_cmp_tid_i,
    output logic             issue_valid_o,
    output logic [TID_W-1:0] issue_tid_o,
    output logic [TID_W-1:0] issue_cmp_tid_o,
    output logic             pop_ok_o,
    output logic             idle_o,
    output logic             underflow_o
);

    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

    logic             valid_q, valid_d;
    logic [TID_W-1:0] tid_q, tid_d;
    logic [TID_W-1:0] cmp_q, cmp_d;
    logic [CW-1:0]    inflight_q, inflight_d;

    always_comb begin
        valid_d    = valid_q;
        tid_d      = tid_q;
        cmp_d      = cmp_q;
        inflight_d = inflight_q;
        if (pop_i) begin
            valid_d = 1'b1;
            tid_d   = head_tid_i;
            cmp_d   = head_cmp_tid_i;
        end else if (valid_q && issue_ready_i) begin
            valid_d = 1'b0;
        end
        // Pop and retire together leave the count unchanged; a retire at zero only flags.
        case ({pop_i, retire_i})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            tid_q      <= '0;
            cmp_q      <= '0;
            inflight_q <= '0;
        end else begin
            valid_q    <= valid_d;
            tid_q      <= tid_d;
            cmp_q      <= cmp_d;
            inflight_q <= inflight_d;
        end
    end

    assign issue_valid_o   = valid_q;
    assign issue_tid_o     = tid_q;
    assign issue_cmp_tid_o = cmp_q;
    assign pop_ok_o        = (!valid_q || issue_ready_i) && (inflight_q < MAX_C);
    assign idle_o          = !valid_q && (inflight_q == '0);
    assign underflow_o     = retire_i && (inflight_q == '0);

endmodule

// File: rtl/cgra_thread_issue.sv
// Thread issue block: pops lane FIFOs per unrolling factor, issues to CGRA lanes, tracks completion.
// Optional THREAD_ISSUE_LOCKSTEP_EN makes all active lanes pop only together.
module cgra_thread_issue
    import dice_dispatch_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 unrolling_factor,
    input  logic                       last_thread,
    cgra_thread_issue_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err_underflow
);

    issue_state_e state_q, state_d;
    unroll_e      uf_q, uf_d;
    logic         err_q;

    logic [NUM_LANES-1:0] mask;
    logic [NUM_LANES-1:0] cand;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] pop_ok;
    logic [NUM_LANES-1:0] idle;
    logic [NUM_LANES-1:0] underflow;
    logic [NUM_LANES-1:0] valid;
    logic                 running;
    logic                 drained;

    logic [2*TID_W-1:0] head [NUM_LANES];
    logic [TID_W-1:0]   tid  [NUM_LANES];
    logic [TID_W-1:0]   cmp  [NUM_LANES];

    assign head[0] = bus.fifo_data_0;
    assign head[1] = bus.fifo_data_1;
    assign head[2] = bus.fifo_data_2;
    assign head[3] = bus.fifo_data_3;

    assign mask    = active_mask(uf_q);
    assign running = (state_q == RUN) || (state_q == DRAIN);
    assign cand    = {NUM_LANES{running}} & mask & bus.fifo_data_valid & pop_ok;

`ifdef THREAD_ISSUE_LOCKSTEP_EN
    // Group pop: inactive lanes count as satisfied so only the active set gates.
    assign pop = (running && ((cand | ~mask) == '1)) ? cand : '0;
`else
    assign pop = cand;
`endif

    assign drained = ((~mask | (~bus.fifo_data_valid & idle)) == '1);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_issue_slot #(
            .MAX_INFLIGHT(MAX_INFLIGHT)
        ) u_slot (
            .clk            (clk),
            .rst            (rst),
            .pop_i          (pop[i]),
            .retire_i       (bus.retire[i]),
            .issue_ready_i  (bus.issue_ready[i]),
            .head_tid_i     (head[i][TID_W-1:0]),
            .head_cmp_tid_i (head[i][CMP_LSB +: TID_W]),
            .issue_valid_o  (valid[i]),
            .issue_tid_o    (tid[i]),
            .issue_cmp_tid_o(cmp[i]),
            .pop_ok_o       (pop_ok[i]),
            .idle_o         (idle[i]),
            .underflow_o    (underflow[i])
        );
    end

    always_comb begin
        state_d = state_q;
        uf_d    = uf_q;
        case (state_q)
            IDLE: begin
                if (start && (unrolling_factor != 2'b11)) begin
                    state_d = RUN;
                    uf_d    = unroll_e'(unrolling_factor);
                end
            end
            RUN:     if (last_thread) state_d = DRAIN;
            DRAIN:   if (drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            uf_q    <= UF1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uf_q    <= uf_d;
            err_q   <= err_q | (|underflow);
        end
    end

    assign bus.fifo_pop        = pop;
    assign bus.issue_valid     = valid;
    assign bus.issue_tid_0     = tid[0];
    assign bus.issue_tid_1     = tid[1];
    assign bus.issue_tid_2     = tid[2];
    assign bus.issue_tid_3     = tid[3];
    assign bus.issue_cmp_tid_0 = cmp[0];
    assign bus.issue_cmp_tid_1 = cmp[1];
    assign bus.issue_cmp_tid_2 = cmp[2];
    assign bus.issue_cmp_tid_3 = cmp[3];

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err_underflow = err_q;

endmodule

// File: doc/cgra_thread_issue.md
Name: cgra_thread_issue

Overview:
- Consumer end of the dispatcher's per-lane thread FIFOs (show-ahead, unregistered read).
- Pops {compared_tid, real_tid} entries from up to 4 lane FIFOs according to the latched unrolling factor. Each popped entry is registered into a per-lane issue slot and presented to the CGRA lane pipeline with a valid/ready handshake.
- Bounds the threads in flight per lane with a credit counter. Signals block completion once every active lane has drained and retired all of its threads.

Parameters:
- NUM_LANES, 4, lane count; fixed at 4 for this revision.
- TID_W, 10, width of real_tid and compared_tid.
- MAX_INFLIGHT, 4, maximum popped-but-unretired threads per lane (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse; begins a block; samples unrolling_factor
- unrolling_factor  in  2  00=1 lane, 01=2 lanes, 10=4 lanes, 11=illegal
- last_thread  in  1  level; dispatcher has pushed all threads of the block
- fifo_data_0..3  in  20 each  [19:10]=compared_tid, [9:0]=real_tid
- fifo_data_valid  in  4  per-lane FIFO head valid
- fifo_pop  out  4  per-lane pop; consumes head in same cycle
- issue_valid  out  4  per-lane issue valid
- issue_tid_0..3  out  10 each  real_tid
- issue_cmp_tid_0..3  out  10 each  compared_tid
- issue_ready  in  4  per-lane pipeline accept
- retire  in  4  per-lane thread-retired pulse
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on block completion
- err_underflow  out  1  sticky; retire seen with zero in flight

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. fifo_pop, issue_valid, done, err_underflow=0. Issue data regs=0. In-flight counters=0. Reset mid-block aborts everything immediately, with no done pulse.
- Active lanes:
  - UF=00: lane 0 only.
  - UF=01: lanes 0,1.
  - UF=10: all 4 lanes.
  - UF=11: start is ignored, state stays IDLE.
- FSM:
  - IDLE --start (legal UF)--> RUN; UF latched on this transition.
  - RUN --last_thread=1--> DRAIN.
  - DRAIN --all active lanes have fifo_data_valid=0, issue_valid=0 and inflight=0--> DONE.
  - DONE --unconditional--> IDLE; done=1 only while in DONE.
  - start outside IDLE is ignored. A UF change after start is ignored.
- Pop rule, per active lane, combinational: fifo_pop[i] = (RUN|DRAIN) & fifo_data_valid[i] & (!issue_valid[i] | issue_ready[i]) & (inflight[i] < MAX_INFLIGHT).
  - Inactive lanes never pop.
  - In IDLE and DONE, fifo_pop=0.
- Issue slot: on fifo_pop[i], issue regs load the head and issue_valid[i]=1 next cycle. Latency is 1 cycle from pop to issue_valid.
  - Handshake: issue_valid & issue_ready with no pop → issue_valid clears. With a simultaneous pop → back-to-back, one thread per cycle per lane.
  - While issue_valid=1 & issue_ready=0: data and valid hold stable.
- In-flight counter per lane, width clog2(MAX_INFLIGHT+1):
  - +1 on pop, -1 on retire; both in the same cycle → unchanged.
  - Saturates at MAX_INFLIGHT: the pop rule blocks further pops.
  - retire with inflight=0 → counter stays 0 and err_underflow sets. err_underflow clears only on rst.
- Retire pulses on inactive lanes are treated identically (counter stays 0, error flags).
- last_thread deasserting after DRAIN is entered has no effect.

Optional Feature:
- Macro THREAD_ISSUE_LOCKSTEP_EN.
- Defined: all active lanes pop together. Group pop occurs only when every active lane satisfies its pop condition, so issue_valid rises simultaneously on all active lanes. Individual lane handshakes still complete independently.
- Undefined: lanes pop independently per the rule above.

Decomposition:
- Package dice_dispatch_pkg holds:
  - constants NUM_LANES, TID_W, CMP_LSB=10
  - typedef issue_state_e {IDLE, RUN, DRAIN, DONE}
  - typedef unroll_e {UF1=2'b00, UF2=2'b01, UF4=2'b10}
  - function active_mask(unroll_e) → [3:0]
- Sub-module lane_issue_slot, instantiated 4×:
  - issue register plus in-flight counter per lane
  - outputs pop_ok and underflow
- The top level holds the FSM, the lane mask, lockstep gating and the done logic.

Test Plan:
- UF=00 → after start, lane 0 FIFO presents 0x00C03, issue_ready=1.
  - Required: fifo_pop[0]=1 that cycle; next cycle issue_valid[0]=1, issue_tid_0=0x003, issue_cmp_tid_0=0x003.
  - Required: fifo_pop[3:1]=0 throughout.
- UF=10, all FIFOs valid, issue_ready=0 for 3 cycles:
  - Each lane pops once, then holds data stable.
  - Credits: with MAX_INFLIGHT=2 and ready=1 but no retire, each lane pops exactly 2 entries then stalls. One retire[2] pulse → lane 2 pops one more.
- Same-cycle pop+retire at inflight=MAX_INFLIGHT-1 → counter unchanged; the next pop is permitted.
- Completion: UF=01, push 3 threads per lane, assert last_thread, retire all 6.
  - Required: done is a single pulse exactly 2 cycles after the final retire (DRAIN→DONE, DONE→IDLE); busy drops with it.
- Error and illegal inputs:
  - retire[1] in IDLE → err_underflow=1 and stays 1 until rst.
  - start with UF=11 → state stays IDLE, busy=0.
- Reset mid-DRAIN with issue_valid=4'b1111 → next cycle all outputs 0, no done pulse.
- With THREAD_ISSUE_LOCKSTEP_EN and UF=10, lane 3 FIFO empty → no pops until lane 3 is valid, then 4'b1111 pop in one cycle.
